// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: hazard unit states, forwarding selectors
// and the architectural zero register.
package cpu_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    LD_STALL,
    BR_FLUSH
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

  // The younger MEM result shadows the older WB result; XZR always reads as the RF value.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] src,
    input logic       reg_write_mem,
    input logic [4:0] rd_mem,
    input logic       reg_write_wb,
    input logic [4:0] rd_wb
  );
    if (reg_write_mem && (rd_mem == src) && (rd_mem != XZR)) return FWD_MEM;
    if (reg_write_wb && (rd_wb == src) && (rd_wb != XZR)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one ALU source: picks MEM result, WB data or
// register-file read data.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [63:0] rf_data,
  input  logic        reg_write_mem,
  input  logic [4:0]  rd_mem,
  input  logic [63:0] alu_result_mem,
  input  logic        reg_write_wb,
  input  logic [4:0]  rd_wb,
  input  logic [63:0] wb_data,
  output logic [63:0] fwd_data
);

  fwd_sel_t sel;

  assign sel = fwd_select(src, reg_write_mem, rd_mem, reg_write_wb, rd_wb);

  always_comb begin
    case (sel)
      FWD_MEM: fwd_data = alu_result_mem;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit: EX operand forwarding, one-bubble load-use
// stall, multi-cycle branch flush and saturating stall/flush statistics.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_ex,
  input  logic [4:0]       Rm_ex,
  input  logic [63:0]      rd1_ex,
  input  logic [63:0]      rd2_ex,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Rm_id,
  input  logic             MemRead_ex,
  input  logic [4:0]       Rd_ex,
  input  logic             RegWrite_mem,
  input  logic [4:0]       Rd_mem,
  input  logic [63:0]      alu_result_mem,
  input  logic             RegWrite_wb,
  input  logic [4:0]       Rd_for,
  input  logic [63:0]      wb_data,
  input  logic             BrTaken_mem,
  output logic [63:0]      fwd_a,
  output logic [63:0]      fwd_b,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state, state_next;
  logic [2:0] flush_cnt, flush_cnt_next;
  logic       load_use;
  logic       br_accept;

  fwd_mux u_fwd_a (
    .src            (Rn_ex),
    .rf_data        (rd1_ex),
    .reg_write_mem  (RegWrite_mem),
    .rd_mem         (Rd_mem),
    .alu_result_mem (alu_result_mem),
    .reg_write_wb   (RegWrite_wb),
    .rd_wb          (Rd_for),
    .wb_data        (wb_data),
    .fwd_data       (fwd_a)
  );

  fwd_mux u_fwd_b (
    .src            (Rm_ex),
    .rf_data        (rd2_ex),
    .reg_write_mem  (RegWrite_mem),
    .rd_mem         (Rd_mem),
    .alu_result_mem (alu_result_mem),
    .reg_write_wb   (RegWrite_wb),
    .rd_wb          (Rd_for),
    .wb_data        (wb_data),
    .fwd_data       (fwd_b)
  );

  assign load_use  = MemRead_ex && (Rd_ex != XZR) && ((Rd_ex == Rn_id) || (Rd_ex == Rm_id));
  assign br_accept = BrTaken_mem && !reset;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next     = state;
    flush_cnt_next = flush_cnt;
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    idex_bubble    = 1'b0;
    flush          = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, LD_STALL: begin
          // A taken branch squashes the instruction that would have caused the stall.
          if (BrTaken_mem) begin
            flush          = 1'b1;
            flush_cnt_next = FLUSH_RELOAD;
            state_next     = (FLUSH_CYCLES == 1) ? IDLE : BR_FLUSH;
          end else if ((state == IDLE) && load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            state_next    = LD_STALL;
          end else begin
            state_next = IDLE;
          end
        end
        BR_FLUSH: begin
          flush = 1'b1;
          if (BrTaken_mem) begin
            flush_cnt_next = FLUSH_RELOAD;
          end else begin
            flush_cnt_next = flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (idex_bubble && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (br_accept && !(&flush_count))   flush_count <= flush_count + 1'b1;
    end
  end

endmodule
